apb_master_bridge: RTL

APB4 requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers. It returns each completion on a registered valid/ready response channel. It drives the APB bus toward slaves such as the team's dual-port memory. It also enforces a bounded wait on PREADY and reports a timeout error.

---
 rtl/apb_master_bridge_if.sv | 57 +++++
 rtl/apb_master_bridge.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the command stream, the response stream and the APB4 bus of the
// apb_master_bridge into one interface.
//   master modport : the bridge's view (takes commands, returns responses,
//                    drives the APB request signals, samples the slave reply)
//   slave  modport : the environment's view (mirror of master)
// Command : cmd_valid/cmd_ready handshake, cmd_write, cmd_addr, cmd_wdata, cmd_strb
// Response: rsp_valid/rsp_ready handshake, rsp_rdata, rsp_err, rsp_timeout
// APB     : PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PRDATA, PREADY, PSLVERR
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// APB4 requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns each completion on a single-entry registered response
// slot. A bounded wait on PREADY aborts the transfer with a timeout error.
// Ports:
//   PCLK    : clock, rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : apb_master_bridge_if.master (command, response and APB signals)
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  // Last counter value before expiry: the ACCESS cycle seen with this count
  // and PREADY low is the TIMEOUT_CYCLES-th waited cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  live_q;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  cmd_ready_s;

  // live_q keeps cmd_ready low while reset is held, without a combinational
  // path from PRESETn into the handshake.
  assign cmd_ready_s = live_q && (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // Next-state, APB request and response-slot logic.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    // Draining the slot; a completion below can only occur while the slot is
    // empty because commands are only accepted once it drains.
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_s) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          // Reads put no data or strobes on the bus.
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end else begin
          state_d   = IDLE;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = 8'd0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over an expiring count.
        if (bus.PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          cnt_d         = cnt_q + 8'd1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d         = cnt_q + 8'd1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      live_q        <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      cnt_q         <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      live_q        <= 1'b1;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule
